// File: rtl/apb_pkg.sv
// Shared APB definitions: completer FSM state encoding and PPROT bit positions.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } apb_state_e;

    localparam int APB_PROT_PRIV   = 0;
    localparam int APB_PROT_SECURE = 1;
    localparam int APB_PROT_INSTR  = 2;

    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/apb_reg_completer.sv
// APB completer backed by N_REGS 32-bit registers with byte strobes,
// programmable wait states and SLVERR on misaligned/out-of-range accesses.
// Optional build macro APB_COMPLETER_PROT_EN: writes with PPROT[0]=0 are errors.
module apb_reg_completer
    import apb_pkg::*;
#(
    parameter int APB_AW      = 32,
    parameter int APB_DW      = 32,
    parameter int APB_SW      = APB_DW / 8,
    parameter int N_REGS      = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                     ckApb,
    input  logic                     rstApb_n,
    input  logic                     apbPSel,
    input  logic                     apbPEnable,
    input  logic                     apbPWrite,
    input  logic [APB_AW-1:0]        apbPAddr,
    input  logic [APB_DW-1:0]        apbPWData,
    input  logic [APB_SW-1:0]        apbPStrb,
    input  logic [2:0]               apbPProt,
    output logic [APB_DW-1:0]        apbPRData,
    output logic                     apbPReady,
    output logic                     apbPSlvErr,
    output logic [N_REGS*APB_DW-1:0] regQ
);

    localparam int IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam logic [APB_AW-3:0] IDX_LIMIT = (APB_AW-2)'(N_REGS);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : {WAIT_CNT_W{1'b0}};

    apb_state_e              state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [APB_AW-1:0]       addr_q;
    logic                    write_q;
    logic [APB_DW-1:0]       wdata_q;
    logic [APB_SW-1:0]       strb_q;
    logic                    ready_q, ready_d;
    logic                    slverr_q, slverr_d;
    logic [APB_DW-1:0]       rdata_q, rdata_d;
    logic [APB_DW-1:0]       regs_q [N_REGS];

    logic                    setup_s;
    logic                    commit_s;
    logic [APB_AW-1:0]       dec_addr_s;
    logic                    dec_write_s;
    logic [APB_AW-3:0]       dec_idx_s;
    logic                    dec_err_s;
    logic [APB_DW-1:0]       dec_rdata_s;

    assign setup_s = apbPSel & ~apbPEnable;

`ifdef APB_COMPLETER_PROT_EN
    logic prot_priv_q;
    logic dec_priv_s;
`else
    logic unused_prot_s;
    assign unused_prot_s = ^apbPProt;
`endif

    // Decode from live bus in IDLE (zero-wait response) or from the latched request otherwise.
    always_comb begin
        if (state_q == IDLE) begin
            dec_addr_s  = apbPAddr;
            dec_write_s = apbPWrite;
`ifdef APB_COMPLETER_PROT_EN
            dec_priv_s  = apbPProt[APB_PROT_PRIV];
`endif
        end else begin
            dec_addr_s  = addr_q;
            dec_write_s = write_q;
`ifdef APB_COMPLETER_PROT_EN
            dec_priv_s  = prot_priv_q;
`endif
        end
    end

    assign dec_idx_s = dec_addr_s[APB_AW-1:2];
`ifdef APB_COMPLETER_PROT_EN
    assign dec_err_s = (dec_addr_s[1:0] != 2'b00) || (dec_idx_s >= IDX_LIMIT) ||
                       (dec_write_s && !dec_priv_s);
`else
    assign dec_err_s = (dec_addr_s[1:0] != 2'b00) || (dec_idx_s >= IDX_LIMIT);
`endif
    assign dec_rdata_s = (dec_err_s || dec_write_s) ? {APB_DW{1'b0}}
                                                    : regs_q[dec_idx_s[IDX_W-1:0]];

    // FSM state and wait counter register.
    always_ff @(posedge ckApb or negedge rstApb_n) begin
        if (!rstApb_n) begin
            state_q <= IDLE;
            cnt_q   <= {WAIT_CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: setup starts a transfer, PSEL low aborts, PENABLE in RESP completes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (setup_s) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        cnt_d   = {WAIT_CNT_W{1'b0}};
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end else begin
                    state_d = IDLE;
                    cnt_d   = {WAIT_CNT_W{1'b0}};
                end
            end
            WAIT: begin
                if (!apbPSel) begin
                    state_d = IDLE;
                    cnt_d   = {WAIT_CNT_W{1'b0}};
                end else if (cnt_q == {WAIT_CNT_W{1'b0}}) begin
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q - {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
                end
            end
            RESP: begin
                if (!apbPSel || apbPEnable) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {WAIT_CNT_W{1'b0}};
            end
        endcase
    end

    // Output logic: load response on entry to RESP, hold while waiting for PENABLE, else clear.
    always_comb begin
        ready_d  = 1'b0;
        slverr_d = 1'b0;
        rdata_d  = {APB_DW{1'b0}};
        commit_s = 1'b0;
        case (state_q)
            IDLE, WAIT: begin
                if (state_d == RESP) begin
                    ready_d  = 1'b1;
                    slverr_d = dec_err_s;
                    rdata_d  = dec_rdata_s;
                end else begin
                    ready_d  = 1'b0;
                end
            end
            RESP: begin
                if (apbPSel && !apbPEnable) begin
                    ready_d  = ready_q;
                    slverr_d = slverr_q;
                    rdata_d  = rdata_q;
                end else begin
                    commit_s = apbPSel && apbPEnable && write_q && !slverr_q;
                end
            end
            default: begin
                ready_d  = 1'b0;
            end
        endcase
    end

    // Registered APB response outputs.
    always_ff @(posedge ckApb or negedge rstApb_n) begin
        if (!rstApb_n) begin
            ready_q  <= 1'b0;
            slverr_q <= 1'b0;
            rdata_q  <= {APB_DW{1'b0}};
        end else begin
            ready_q  <= ready_d;
            slverr_q <= slverr_d;
            rdata_q  <= rdata_d;
        end
    end

    // Capture the request at the setup phase so wait states see stable values.
    always_ff @(posedge ckApb or negedge rstApb_n) begin
        if (!rstApb_n) begin
            addr_q      <= {APB_AW{1'b0}};
            write_q     <= 1'b0;
            wdata_q     <= {APB_DW{1'b0}};
            strb_q      <= {APB_SW{1'b0}};
`ifdef APB_COMPLETER_PROT_EN
            prot_priv_q <= 1'b0;
`endif
        end else if (state_q == IDLE && setup_s) begin
            addr_q      <= apbPAddr;
            write_q     <= apbPWrite;
            wdata_q     <= apbPWData;
            strb_q      <= apbPStrb;
`ifdef APB_COMPLETER_PROT_EN
            prot_priv_q <= apbPProt[APB_PROT_PRIV];
`endif
        end
    end

    // Register file: byte-strobed write commit on the completion edge.
    always_ff @(posedge ckApb or negedge rstApb_n) begin
        if (!rstApb_n) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs_q[i] <= {APB_DW{1'b0}};
            end
        end else if (commit_s) begin
            for (int i = 0; i < N_REGS; i++) begin
                if (addr_q[APB_AW-1:2] == (APB_AW-2)'(i)) begin
                    for (int b = 0; b < APB_SW; b++) begin
                        if (strb_q[b]) begin
                            regs_q[i][b*8 +: 8] <= wdata_q[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    assign apbPReady  = ready_q;
    assign apbPSlvErr = slverr_q;
    assign apbPRData  = rdata_q;

    for (genvar g = 0; g < N_REGS; g++) begin : g_regq
        assign regQ[g*APB_DW +: APB_DW] = regs_q[g];
    end

endmodule

// File: tb/tb_apb_reg_completer.sv
// Directed scoreboard bench: two completers (0 and 3 wait states) on a shared,
// per-DUT-gated APB bus; responses are checked against a register model.
module tb_apb_reg_completer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    int          dsel;

    logic        psel0, psel1, pen0, pen1;
    logic [31:0] rdata0, rdata1;
    logic        ready0, ready1, err0, err1;
    logic [255:0] regq0, regq1;

    assign psel0 = psel & (dsel == 0);
    assign psel1 = psel & (dsel == 1);
    assign pen0  = penable & (dsel == 0);
    assign pen1  = penable & (dsel == 1);

    logic        ready_s, err_s;
    logic [31:0] rdata_s;
    logic [255:0] regq_s;
    assign ready_s = (dsel == 0) ? ready0 : ready1;
    assign err_s   = (dsel == 0) ? err0   : err1;
    assign rdata_s = (dsel == 0) ? rdata0 : rdata1;
    assign regq_s  = (dsel == 0) ? regq0  : regq1;

    apb_reg_completer #(.WAIT_CYCLES(0)) u_dut0 (
        .ckApb(clk), .rstApb_n(rst_n),
        .apbPSel(psel0), .apbPEnable(pen0), .apbPWrite(pwrite),
        .apbPAddr(paddr), .apbPWData(pwdata), .apbPStrb(pstrb), .apbPProt(pprot),
        .apbPRData(rdata0), .apbPReady(ready0), .apbPSlvErr(err0), .regQ(regq0)
    );

    apb_reg_completer #(.WAIT_CYCLES(3)) u_dut1 (
        .ckApb(clk), .rstApb_n(rst_n),
        .apbPSel(psel1), .apbPEnable(pen1), .apbPWrite(pwrite),
        .apbPAddr(paddr), .apbPWData(pwdata), .apbPStrb(pstrb), .apbPProt(pprot),
        .apbPRData(rdata1), .apbPReady(ready1), .apbPSlvErr(err1), .regQ(regq1)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [2][8];
    int          n_cmp  = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] pack(input int d);
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = mem[d][i];
        return v;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++) mem[d][i] = 32'h0;
    endtask

    task automatic bus_idle();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0; pprot = 3'b000;
    endtask

    // One full transfer; hold keeps PSEL/PENABLE high for extra cycles after completion.
    task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] dat,
                        input logic [3:0] s, input logic [2:0] p, input int hold);
        exp_t e, got;
        bit   er;
        int   idx;
        int   waits;
        int   exp_wait;
        er = (a[1:0] != 2'b00) || (a[31:2] >= 30'd8);
`ifdef APB_COMPLETER_PROT_EN
        if (w && !p[0]) er = 1'b1;
`endif
        idx = er ? 0 : int'(a[4:2]);
        e.err   = er;
        e.rdata = (er || w) ? 32'h0 : mem[d][idx];
        sb.push_back(e);
        exp_wait = (d == 0) ? 0 : 3;

        dsel = d;
        psel = 1'b1; penable = 1'b0; pwrite = w;
        paddr = a; pwdata = dat; pstrb = s; pprot = p;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        while (ready_s !== 1'b1 && waits < 40) begin
            waits++;
            @(posedge clk); #1;
        end
        chk("wait_cycles", 256'(waits), 256'(exp_wait));
        got = sb.pop_front();
        chk("slverr", {255'h0, err_s}, {255'h0, got.err});
        chk("rdata", {224'h0, rdata_s}, {224'h0, got.rdata});

        if (!er && w) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) mem[d][idx][b*8 +: 8] = dat[b*8 +: 8];
        end
        @(posedge clk); #1;
        chk("ready_clr", {255'h0, ready_s}, 256'h0);
        chk("slverr_clr", {255'h0, err_s}, 256'h0);
        chk("rdata_clr", {224'h0, rdata_s}, 256'h0);
        chk("regq", regq_s, pack(d));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_no_ready", {255'h0, ready_s}, 256'h0);
        end
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        chk("regq_after", regq_s, pack(d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        bus_idle();
        dsel  = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {255'h0, ready0}, 256'h0);
        chk("rst_slverr", {255'h0, err0}, 256'h0);
        chk("rst_rdata", {224'h0, rdata0}, 256'h0);
        chk("rst_regq0", regq0, 256'h0);
        chk("rst_regq1", regq1, 256'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero-wait write then read back
        xfer(0, 1'b1, 32'h04, 32'h12345678, 4'hF, 3'b001, 0);
        xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 3'b001, 0);
        chk("regq0_word1", {224'h0, regq0[63:32]}, {224'h0, 32'h12345678});

        // Misaligned write and out-of-range read
        xfer(0, 1'b1, 32'h02, 32'hFFFFFFFF, 4'hF, 3'b001, 0);
        xfer(0, 1'b0, 32'h20, 32'h0, 4'hF, 3'b001, 0);

        // Zero strobe write is a legal no-op
        xfer(0, 1'b1, 32'h04, 32'hFFFFFFFF, 4'h0, 3'b001, 0);

        // Unprivileged write: error only when protection check is built in
        xfer(0, 1'b1, 32'h00, 32'hFFFFFFFF, 4'hF, 3'b000, 0);
        xfer(0, 1'b0, 32'h00, 32'h0, 4'hF, 3'b001, 0);

        // Three wait states, partial strobe
        xfer(1, 1'b1, 32'h08, 32'hAABBCCDD, 4'hF, 3'b001, 0);
        xfer(1, 1'b1, 32'h08, 32'h11223344, 4'b0101, 3'b001, 0);
        xfer(1, 1'b0, 32'h08, 32'h0, 4'h0, 3'b001, 0);
        chk("regq1_word2", {224'h0, regq1[95:64]}, {224'h0, 32'hAA22CC44});

        // Bus held high after completion must not start a new transfer
        xfer(0, 1'b1, 32'h0C, 32'hCAFEF00D, 4'hF, 3'b001, 3);

        // Abort in WAIT: PSEL dropped during the second access cycle
        dsel = 1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h10; pwdata = 32'hDEADBEEF; pstrb = 4'hF; pprot = 3'b001;
        @(posedge clk); #1;
        penable = 1'b1;
        chk("abort_wait1", {255'h0, ready1}, 256'h0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            chk("abort_no_ready", {255'h0, ready1}, 256'h0);
        end
        chk("abort_regq1", regq1, pack(1));

        // Asynchronous reset while in RESP
        dsel = 0;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h14; pwdata = 32'h55AA55AA; pstrb = 4'hF; pprot = 3'b001;
        @(posedge clk); #1;
        penable = 1'b1;
        chk("resp_ready", {255'h0, ready0}, 256'h1);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("arst_ready", {255'h0, ready0}, 256'h0);
        chk("arst_slverr", {255'h0, err0}, 256'h0);
        chk("arst_rdata", {224'h0, rdata0}, 256'h0);
        chk("arst_regq0", regq0, 256'h0);
        chk("arst_regq1", regq1, 256'h0);
        @(negedge clk);
        rst_n = 1'b1;
        // Bus still in access phase after release: no transfer without a new setup
        repeat (3) begin
            @(posedge clk); #1;
            chk("post_rst_no_ready", {255'h0, ready0}, 256'h0);
        end
        chk("post_rst_regq0", regq0, 256'h0);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        xfer(0, 1'b0, 32'h14, 32'h0, 4'hF, 3'b001, 0);
        xfer(0, 1'b0, 32'h04, 32'h0, 4'hF, 3'b001, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
